// File: rtl/multicycle_uc_pkg.sv
// Shared constants for the multicycle RV32I control unit: state encodings,
// opcodes, ALU operation classes and datapath mux select codes.
package mc_uc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    // ALU instructions whose funct3 maps to an implemented operation.
    function automatic logic f3_alu_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/multicycle_uc_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle control unit.
interface multicycle_uc_if #(parameter int ALU_CTRL_W = 3);
    logic [6:0]            op;
    logic [2:0]            f3;
    logic                  f7;
    logic                  zero;
    logic                  pcWrite;
    logic                  adrSrc;
    logic                  memWrite;
    logic                  irWrite;
    logic [1:0]            resSrc;
    logic [1:0]            aluSrcA;
    logic [1:0]            aluSrcB;
    logic [ALU_CTRL_W-1:0] ALUcontrol;
    logic [1:0]            immSrc;
    logic                  regWrite;
    logic                  illegal;
    logic [3:0]            state_o;

    modport master (
        output op, f3, f7, zero,
        input  pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
               ALUcontrol, immSrc, regWrite, illegal, state_o
    );

    modport slave (
        input  op, f3, f7, zero,
        output pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
               ALUcontrol, immSrc, regWrite, illegal, state_o
    );
endinterface

// File: rtl/multicycle_uc_alu_dec.sv
// Combinational ALU control decode from ALU operation class and funct fields.
module alu_decoder_mc
    import mc_uc_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  aluop_e                aluop,
    input  logic [2:0]            f3,
    input  logic                  op5,
    input  logic                  f7,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);
    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // Only R-type (op[5]=1) can subtract; addi ignores IR[30].
                    3'b000:  code = (op5 && f7) ? ALU_SUB : ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default:     code = ALU_ADD;
        endcase
        alu_ctrl = ALU_CTRL_W'(code);
    end
endmodule

// File: rtl/multicycle_uc.sv
// Multicycle RV32I control unit: Moore sequencing FSM with registered state,
// combinational output table, ALU decode and immediate-format decode.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR/oldPC, PC <= PC+4
// DECODE   | branch target oldPC+imm into ALUOut, dispatch on opcode
// MEMADR   | rs1+imm effective address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, load PC from ALUOut if taken
// JAL      | PC <= target, ALUOut <= oldPC+4
// TRAP     | illegal instruction seen; held until reset
module multicycle_uc
    import mc_uc_pkg::*;
#(
    parameter int ALU_CTRL_W      = 3,
    parameter int HAS_BNE         = 1,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input logic            clk,
    input logic            rst,
    multicycle_uc_if.slave bus
);
    localparam logic [3:0] S_ILLEGAL = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

    logic [3:0] state, state_nx;
    logic       pc_upd, branch, taken, br_ok;
    logic       ir_w, mem_w, reg_w;
    aluop_e     aluop;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    assign br_ok = (bus.f3 == 3'b000) || ((HAS_BNE != 0) && (bus.f3 == 3'b001));
    assign taken = ((bus.f3 == 3'b000) && bus.zero) ||
                   ((HAS_BNE != 0) && (bus.f3 == 3'b001) && !bus.zero);

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_R:         state_nx = f3_alu_ok(bus.f3) ? S_EXECR : S_ILLEGAL;
                    OP_I:         state_nx = f3_alu_ok(bus.f3) ? S_EXECI : S_ILLEGAL;
                    OP_BR:        state_nx = br_ok ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       state_nx = S_JAL;
                    default:      state_nx = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_nx = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nx = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_nx = S_ALUWB;
            S_TRAP:     state_nx = S_TRAP;
            default:    state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        pc_upd      = 1'b0;
        branch      = 1'b0;
        ir_w        = 1'b0;
        mem_w       = 1'b0;
        reg_w       = 1'b0;
        aluop       = ALUOP_ADD;
        bus.adrSrc  = 1'b0;
        bus.resSrc  = RES_ALUOUT;
        bus.aluSrcA = SRCA_PC;
        bus.aluSrcB = SRCB_RS2;
        bus.illegal = 1'b0;
        case (state)
            S_FETCH:    begin ir_w = 1'b1; pc_upd = 1'b1; bus.aluSrcB = SRCB_FOUR; bus.resSrc = RES_ALU; end
            S_DECODE:   begin bus.aluSrcA = SRCA_OLDPC; bus.aluSrcB = SRCB_IMM; end
            S_MEMADR:   begin bus.aluSrcA = SRCA_RS1; bus.aluSrcB = SRCB_IMM; end
            S_MEMREAD:  bus.adrSrc = 1'b1;
            S_MEMWB:    begin bus.resSrc = RES_DATA; reg_w = 1'b1; end
            S_MEMWRITE: begin bus.adrSrc = 1'b1; mem_w = 1'b1; end
            S_EXECR:    begin bus.aluSrcA = SRCA_RS1; aluop = ALUOP_FUNCT; end
            S_EXECI:    begin bus.aluSrcA = SRCA_RS1; bus.aluSrcB = SRCB_IMM; aluop = ALUOP_FUNCT; end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH:   begin bus.aluSrcA = SRCA_RS1; aluop = ALUOP_SUB; branch = 1'b1; end
            S_JAL:      begin bus.aluSrcA = SRCA_OLDPC; bus.aluSrcB = SRCB_FOUR; pc_upd = 1'b1; end
            S_TRAP:     bus.illegal = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.immSrc = IMM_S;
            OP_BR:   bus.immSrc = IMM_B;
            OP_JAL:  bus.immSrc = IMM_J;
            default: bus.immSrc = IMM_I;
        endcase
    end

    // Reset gates every write enable so an interrupted instruction leaves no side effect.
    assign bus.pcWrite  = !rst && (pc_upd || (branch && taken));
    assign bus.irWrite  = !rst && ir_w;
    assign bus.memWrite = !rst && mem_w;
    assign bus.regWrite = !rst && reg_w;
    assign bus.state_o  = state;

    alu_decoder_mc #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .aluop    (aluop),
        .f3       (bus.f3),
        .op5      (bus.op[5]),
        .f7       (bus.f7),
        .alu_ctrl (bus.ALUcontrol)
    );
endmodule
